kbd_scan_sequencer: RTL and testbench
=====================================

Name: kbd_scan_sequencer

Overview:
- Controller that sits between the PS/2 byte receiver and the character buffer's write port.
- Consumes raw scan-code bytes and tracks make/break/extended prefixes and modifier state (shift, ctrl, caps lock).
- Sequences exactly one single-cycle write strobe with an ASCII byte into the buffer per printable key press.
- Owns the decode state machine; the buffer itself stays a plain FIFO.

Parameters:
- BREAK_CODE, 8'hF0, break (key release) prefix byte
- EXT_CODE, 8'hE0, extended-key prefix byte
- BAT_CODE, 8'hAA, keyboard self-test-passed byte; clears all modifier state

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- scan_in  input  8  scan-code byte from PS/2 receiver
- scan_valid  input  1  one-cycle strobe, scan_in valid
- buf_full  input  1  buffer cannot accept a write this cycle
- wr_char  output  8  ASCII byte to buffer
- wr_en  output  1  one-cycle write strobe to buffer
- dropped  output  1  one-cycle pulse: a printable press was discarded because buf_full was high
- mod_state  output  4  {caps_lock, ctrl, shift_r, shift_l}, for LEDs/debug

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = S_IDLE; all modifiers 0
  - wr_en = 0, wr_char = 8'h00, dropped = 0
- States:
  - S_IDLE: scan_valid with BREAK_CODE -> S_BREAK; EXT_CODE -> S_EXT; BAT_CODE -> clear modifiers, stay; otherwise process a make code, stay.
  - S_EXT: BREAK_CODE -> S_EXT_BREAK; any other byte -> process an extended make, -> S_IDLE.
  - S_BREAK: any byte -> process a release, -> S_IDLE.
  - S_EXT_BREAK: any byte -> process an extended release, -> S_IDLE.
  - A repeated prefix (e.g. E0 E0, or F0 F0) keeps the current prefix state; it does not fall back to S_IDLE.
- Make processing:
  - 8'h12 sets shift_l; 8'h59 sets shift_r; 8'h14 sets ctrl (also E0 14).
  - 8'h58 toggles caps_lock on make only. Typematic repeats of 58 toggle again; this is accepted behaviour.
  - All other codes go to the keymap lookup. Result of 8'h00 means not printable: no write.
- Release processing:
  - Clears shift_l, shift_r or ctrl for the matching code.
  - All other releases are ignored; never a write.
- Case rules:
  - Letters: upper = shift_l|shift_r XOR caps_lock.
  - Non-letters: upper = shift_l|shift_r only.
  - ctrl held with a letter emits letter & 8'h1F (ctrl-A = 8'h01). Ctrl overrides case.
- Extended makes:
  - Only E0 5A -> 8'h0D and E0 4A -> 8'h2F are printable.
  - All other extended codes produce no write.
- Output timing:
  - wr_en/wr_char are registered, asserted the cycle after the accepted scan_valid, high for exactly one cycle.
  - wr_char holds its last value when wr_en is low.
- Back-pressure:
  - If buf_full is high in the cycle scan_valid delivers a printable make: no write, dropped pulses one cycle (same latency as wr_en).
  - Modifier and state updates still occur.
- Back-to-back input:
  - scan_valid on consecutive cycles must be handled with no byte lost.
  - One output write per cycle at most, so no queueing is needed.
- scan_valid low: no state change, wr_en = 0.
- Reset mid-sequence (e.g. after F0): returns to S_IDLE; the next byte is treated as a make.

Decomposition:
- Shared package kbd_pkg holds:
  - state encodings S_IDLE, S_EXT, S_BREAK, S_EXT_BREAK (2 bits)
  - the prefix/BAT constants
  - modifier scan codes (SC_LSHIFT 12, SC_RSHIFT 59, SC_CTRL 14, SC_CAPS 58)
  - the mod_state bit indices
- One sub-module, kbd_keymap_rom: combinational 8-bit scan code -> {is_letter, lower ASCII, upper ASCII}.
  - Covers set-2 codes for letters, digits, punctuation, space 29 -> 8'h20, enter 5A -> 8'h0D, backspace 66 -> 8'h08, tab 0D -> 8'h09.
  - Unmapped codes return zeros.

Test Plan:
- Reset, then 1C -> wr_en one cycle later with wr_char 8'h61; mod_state 4'b0000.
- 12, 1C, F0 1C, F0 12, 1C -> exactly two writes: 8'h41 then 8'h61; mod_state returns to 0 after F0 12.
- 58, F0 58, 1C, 12, 1C -> caps_lock = 1; writes 8'h41 then 8'h61 (shift inverts caps); digit 16 with caps only -> 8'h31.
- 14, 1C, E0 5A, E0 75, E0 F0 75 -> writes 8'h01 then 8'h0D; no write for 75 press or release; state ends S_IDLE.
- buf_full = 1 during 1C -> no wr_en, dropped pulses once; 12 with buf_full = 1 still sets shift_l.
- F0 then rst_n low mid-sequence, then 1C -> write 8'h61 (treated as make); AA while shift held -> mod_state cleared, no write.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code sequencer.
// Covers the decode states, prefix bytes, modifier codes and keymap entry layout.
package kbd_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_EXT       = 2'd1,
      S_BREAK     = 2'd2,
      S_EXT_BREAK = 2'd3
   } kbd_state_e;

   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] SC_BAT      = 8'hAA;

   localparam logic [7:0] SC_LSHIFT   = 8'h12;
   localparam logic [7:0] SC_RSHIFT   = 8'h59;
   localparam logic [7:0] SC_CTRL     = 8'h14;
   localparam logic [7:0] SC_CAPS     = 8'h58;

   // Extended (E0-prefixed) keypad keys that produce characters
   localparam logic [7:0] SC_KP_ENTER = 8'h5A;
   localparam logic [7:0] SC_KP_SLASH = 8'h4A;

   localparam int MOD_SHIFT_L = 0;
   localparam int MOD_SHIFT_R = 1;
   localparam int MOD_CTRL    = 2;
   localparam int MOD_CAPS    = 3;

   typedef struct packed {
      logic       is_letter;
      logic [7:0] lower;
      logic [7:0] upper;
   } keymap_t;

   function automatic keymap_t km(input logic letter, input logic [7:0] lo, input logic [7:0] up);
      keymap_t e;
      e.is_letter = letter;
      e.lower     = lo;
      e.upper     = up;
      return e;
   endfunction

endpackage

// File: rtl/kbd_scan_sequencer_if.sv
// Receiver-side scan bytes in, buffer write port and modifier status out.
// master = the sequencer, slave = the environment driving scans and observing writes.
interface kbd_scan_sequencer_if;
   logic [7:0] scan_in;
   logic       scan_valid;
   logic       buf_full;
   logic [7:0] wr_char;
   logic       wr_en;
   logic       dropped;
   logic [3:0] mod_state;

   modport master (
      input  scan_in, scan_valid, buf_full,
      output wr_char, wr_en, dropped, mod_state
   );

   modport slave (
      output scan_in, scan_valid, buf_full,
      input  wr_char, wr_en, dropped, mod_state
   );
endinterface

// File: rtl/kbd_keymap_rom.sv
// Combinational set-2 make code -> {is_letter, lower ASCII, upper ASCII}.
// Unmapped codes return all zeros, which the sequencer treats as non-printable.
module kbd_keymap_rom
   import kbd_pkg::*;
(
   input  logic [7:0] code_i,
   output keymap_t    entry_o
);

   always_comb begin
      entry_o = '0;
      case (code_i)
         8'h1C: entry_o = km(1'b1, "a", "A");
         8'h32: entry_o = km(1'b1, "b", "B");
         8'h21: entry_o = km(1'b1, "c", "C");
         8'h23: entry_o = km(1'b1, "d", "D");
         8'h24: entry_o = km(1'b1, "e", "E");
         8'h2B: entry_o = km(1'b1, "f", "F");
         8'h34: entry_o = km(1'b1, "g", "G");
         8'h33: entry_o = km(1'b1, "h", "H");
         8'h43: entry_o = km(1'b1, "i", "I");
         8'h3B: entry_o = km(1'b1, "j", "J");
         8'h42: entry_o = km(1'b1, "k", "K");
         8'h4B: entry_o = km(1'b1, "l", "L");
         8'h3A: entry_o = km(1'b1, "m", "M");
         8'h31: entry_o = km(1'b1, "n", "N");
         8'h44: entry_o = km(1'b1, "o", "O");
         8'h4D: entry_o = km(1'b1, "p", "P");
         8'h15: entry_o = km(1'b1, "q", "Q");
         8'h2D: entry_o = km(1'b1, "r", "R");
         8'h1B: entry_o = km(1'b1, "s", "S");
         8'h2C: entry_o = km(1'b1, "t", "T");
         8'h3C: entry_o = km(1'b1, "u", "U");
         8'h2A: entry_o = km(1'b1, "v", "V");
         8'h1D: entry_o = km(1'b1, "w", "W");
         8'h22: entry_o = km(1'b1, "x", "X");
         8'h35: entry_o = km(1'b1, "y", "Y");
         8'h1A: entry_o = km(1'b1, "z", "Z");
         // Digit row, shifted symbols per US layout
         8'h45: entry_o = km(1'b0, "0", ")");
         8'h16: entry_o = km(1'b0, "1", "!");
         8'h1E: entry_o = km(1'b0, "2", "@");
         8'h26: entry_o = km(1'b0, "3", "#");
         8'h25: entry_o = km(1'b0, "4", "$");
         8'h2E: entry_o = km(1'b0, "5", "%");
         8'h36: entry_o = km(1'b0, "6", "^");
         8'h3D: entry_o = km(1'b0, "7", "&");
         8'h3E: entry_o = km(1'b0, "8", "*");
         8'h46: entry_o = km(1'b0, "9", "(");
         8'h0E: entry_o = km(1'b0, 8'h60, 8'h7E);
         8'h4E: entry_o = km(1'b0, "-", "_");
         8'h55: entry_o = km(1'b0, "=", "+");
         8'h5D: entry_o = km(1'b0, 8'h5C, 8'h7C);
         8'h54: entry_o = km(1'b0, "[", "{");
         8'h5B: entry_o = km(1'b0, "]", "}");
         8'h4C: entry_o = km(1'b0, ";", ":");
         8'h52: entry_o = km(1'b0, 8'h27, 8'h22);
         8'h41: entry_o = km(1'b0, ",", "<");
         8'h49: entry_o = km(1'b0, ".", ">");
         8'h4A: entry_o = km(1'b0, "/", "?");
         // Whitespace and control keys are shift-invariant
         8'h29: entry_o = km(1'b0, 8'h20, 8'h20);
         8'h5A: entry_o = km(1'b0, 8'h0D, 8'h0D);
         8'h66: entry_o = km(1'b0, 8'h08, 8'h08);
         8'h0D: entry_o = km(1'b0, 8'h09, 8'h09);
         default: entry_o = '0;
      endcase
   end

endmodule

// File: rtl/kbd_scan_sequencer.sv
// Decodes PS/2 set-2 prefixes and modifiers, and issues one registered write
// strobe per printable key press into a plain FIFO (or a drop pulse when it is full).
module kbd_scan_sequencer
   import kbd_pkg::*;
#(
   parameter logic [7:0] BREAK_CODE = SC_BREAK,
   parameter logic [7:0] EXT_CODE   = SC_EXT,
   parameter logic [7:0] BAT_CODE   = SC_BAT
)(
   input  logic               clk,
   input  logic               rst_n,
   kbd_scan_sequencer_if.master bus
);

   kbd_state_e state_q;
   logic [3:0] mods_q;
   logic [7:0] wr_char_q;
   logic       wr_en_q;
   logic       dropped_q;

   keymap_t    rom_entry;
   logic       shift_any;
   logic       is_break;
   logic       is_ext;
   logic [7:0] make_char;
   logic [7:0] ext_char;
   logic [7:0] out_char;

   kbd_keymap_rom u_keymap (
      .code_i  (bus.scan_in),
      .entry_o (rom_entry)
   );

   assign shift_any = mods_q[MOD_SHIFT_L] | mods_q[MOD_SHIFT_R];
   assign is_break  = (bus.scan_in == BREAK_CODE);
   assign is_ext    = (bus.scan_in == EXT_CODE);

   // Character a plain make would produce; zero means "nothing to write"
   always_comb begin
      make_char = rom_entry.lower;
      if (rom_entry.is_letter) begin
         if (mods_q[MOD_CTRL])
            make_char = rom_entry.lower & 8'h1F;
         else if (shift_any ^ mods_q[MOD_CAPS])
            make_char = rom_entry.upper;
      end else if (shift_any) begin
         make_char = rom_entry.upper;
      end
   end

   always_comb begin
      ext_char = 8'h00;
      if (bus.scan_in == SC_KP_ENTER)
         ext_char = 8'h0D;
      else if (bus.scan_in == SC_KP_SLASH)
         ext_char = 8'h2F;
   end

   always_comb begin
      out_char = 8'h00;
      case (state_q)
         S_IDLE:  if (!is_break && !is_ext && bus.scan_in != BAT_CODE) out_char = make_char;
         S_EXT:   if (!is_break && !is_ext) out_char = ext_char;
         default: out_char = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mods_q    <= 4'b0000;
         wr_char_q <= 8'h00;
         wr_en_q   <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         wr_en_q   <= 1'b0;
         dropped_q <= 1'b0;
         if (bus.scan_valid) begin
            case (state_q)
               S_IDLE: begin
                  if (is_break)                       state_q <= S_BREAK;
                  else if (is_ext)                    state_q <= S_EXT;
                  else if (bus.scan_in == BAT_CODE)   mods_q  <= 4'b0000;
                  else if (bus.scan_in == SC_LSHIFT)  mods_q[MOD_SHIFT_L] <= 1'b1;
                  else if (bus.scan_in == SC_RSHIFT)  mods_q[MOD_SHIFT_R] <= 1'b1;
                  else if (bus.scan_in == SC_CTRL)    mods_q[MOD_CTRL]    <= 1'b1;
                  else if (bus.scan_in == SC_CAPS)    mods_q[MOD_CAPS]    <= ~mods_q[MOD_CAPS];
               end
               S_EXT: begin
                  if (is_break)
                     state_q <= S_EXT_BREAK;
                  else if (!is_ext) begin
                     if (bus.scan_in == SC_CTRL) mods_q[MOD_CTRL] <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
               S_BREAK: begin
                  if (!is_break) begin
                     if (bus.scan_in == SC_LSHIFT) mods_q[MOD_SHIFT_L] <= 1'b0;
                     if (bus.scan_in == SC_RSHIFT) mods_q[MOD_SHIFT_R] <= 1'b0;
                     if (bus.scan_in == SC_CTRL)   mods_q[MOD_CTRL]    <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
               S_EXT_BREAK: begin
                  if (!is_break) begin
                     if (bus.scan_in == SC_CTRL) mods_q[MOD_CTRL] <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase

            if (out_char != 8'h00) begin
               if (bus.buf_full) begin
                  dropped_q <= 1'b1;
               end else begin
                  wr_en_q   <= 1'b1;
                  wr_char_q <= out_char;
               end
            end
         end
      end
   end

   assign bus.wr_char   = wr_char_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.dropped   = dropped_q;
   assign bus.mod_state = mods_q;

endmodule

// File: tb/tb_kbd_scan_sequencer.sv
// Directed scan-code sequences with a write/drop scoreboard checked by a separate monitor.
module tb_kbd_scan_sequencer;
   import kbd_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   kbd_scan_sequencer_if bus ();

   kbd_scan_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic       drop;
      logic [7:0] ch;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic expect_wr(input logic [7:0] ch);
      exp_q.push_back('{drop: 1'b0, ch: ch});
   endtask

   task automatic expect_drop();
      exp_q.push_back('{drop: 1'b1, ch: 8'h00});
   endtask

   task automatic send(input logic [7:0] b, input logic full = 1'b0);
      @(negedge clk);
      bus.scan_in    = b;
      bus.scan_valid = 1'b1;
      bus.buf_full   = full;
   endtask

   task automatic gap();
      @(negedge clk);
      bus.scan_valid = 1'b0;
      bus.buf_full   = 1'b0;
   endtask

   // Monitor: every write or drop pulse must match the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (bus.wr_en === 1'b1 || bus.dropped === 1'b1)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got wr_en=%0b dropped=%0b char=%0h, expected none",
                        bus.wr_en, bus.dropped, bus.wr_char);
            end else begin
               e = exp_q.pop_front();
               $display("out: wr_en=%0b dropped=%0b char=%02h (exp drop=%0b char=%02h)",
                        bus.wr_en, bus.dropped, bus.wr_char, e.drop, e.ch);
               check("dropped", {31'd0, bus.dropped}, {31'd0, e.drop});
               check("wr_en", {31'd0, bus.wr_en}, {31'd0, ~e.drop});
               if (!e.drop) check("wr_char", {24'd0, bus.wr_char}, {24'd0, e.ch});
            end
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      bus.scan_in    = 8'h00;
      bus.scan_valid = 1'b0;
      bus.buf_full   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
      check("rst_wr_char", {24'd0, bus.wr_char}, 32'h00);
      check("rst_dropped", {31'd0, bus.dropped}, 32'd0);
      check("rst_mod", {28'd0, bus.mod_state}, 32'h0);
      rst_n = 1'b1;

      // plain 'a'
      send(8'h1C); expect_wr(8'h61);
      gap(); check("mod_after_a", {28'd0, bus.mod_state}, 32'h0);

      // shift press/release around letters
      send(8'h12);
      send(8'h1C); expect_wr(8'h41);
      send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12);
      gap(); check("mod_shift_released", {28'd0, bus.mod_state}, 32'h0);
      send(8'h1C); expect_wr(8'h61);
      gap();

      // caps lock and shift inversion
      send(8'h58); send(8'hF0); send(8'h58);
      gap(); check("mod_caps_on", {28'd0, bus.mod_state}, 32'h8);
      send(8'h1C); expect_wr(8'h41);
      send(8'h12);
      send(8'h1C); expect_wr(8'h61);
      send(8'hF0); send(8'h12);
      send(8'h16); expect_wr(8'h31);
      send(8'h58); send(8'hF0); send(8'h58);
      gap(); check("mod_caps_off", {28'd0, bus.mod_state}, 32'h0);

      // ctrl letters and extended keys
      send(8'h14);
      gap(); check("mod_ctrl", {28'd0, bus.mod_state}, 32'h4);
      send(8'h1C); expect_wr(8'h01);
      send(8'hE0); send(8'h5A); expect_wr(8'h0D);
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hF0); send(8'h14);
      gap(); check("mod_ctrl_released", {28'd0, bus.mod_state}, 32'h0);
      send(8'h1C); expect_wr(8'h61);

      // shifted digit, space, keypad slash, repeated prefixes
      send(8'h12);
      send(8'h16); expect_wr(8'h21);
      send(8'h29); expect_wr(8'h20);
      send(8'hF0); send(8'h12);
      send(8'hE0); send(8'h4A); expect_wr(8'h2F);
      send(8'hE0); send(8'hE0); send(8'h5A); expect_wr(8'h0D);
      send(8'hF0); send(8'hF0); send(8'h1C);
      send(8'h1C); expect_wr(8'h61);
      send(8'hE0); send(8'h14);
      gap(); check("mod_ext_ctrl", {28'd0, bus.mod_state}, 32'h4);
      send(8'hE0); send(8'hF0); send(8'h14);
      gap(); check("mod_ext_ctrl_rel", {28'd0, bus.mod_state}, 32'h0);
      send(8'h59);
      gap(); check("mod_rshift", {28'd0, bus.mod_state}, 32'h2);
      send(8'h1A); expect_wr(8'h5A);
      send(8'hF0); send(8'h59);
      send(8'h66); expect_wr(8'h08);
      gap();
      check("wr_char_held", {24'd0, bus.wr_char}, 32'h08);

      // back-pressure
      send(8'h1C, 1'b1); expect_drop();
      send(8'h12, 1'b1);
      gap(); check("mod_shift_while_full", {28'd0, bus.mod_state}, 32'h1);
      send(8'h1C); expect_wr(8'h41);
      send(8'hF0); send(8'h12);
      gap();

      // reset after a break prefix
      send(8'hF0);
      gap();
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_mod", {28'd0, bus.mod_state}, 32'h0);
      check("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
      rst_n = 1'b1;
      send(8'h1C); expect_wr(8'h61);

      // BAT clears held modifiers
      send(8'h12); send(8'h58);
      gap(); check("mod_before_bat", {28'd0, bus.mod_state}, 32'h9);
      send(8'hAA);
      gap(); check("mod_after_bat", {28'd0, bus.mod_state}, 32'h0);
      send(8'h1C); expect_wr(8'h61);
      gap();

      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
